// File: rtl/alu_sched.sv
// Round-robin scheduler that shares one combinational ALU between NUM_REQ requesters.
// Operands are latched on accept, executed register-to-register, and returned on a one-hot response channel.

module alu #(
  parameter int unsigned REG_WIDTH = 8
) (
  input  logic [3:0]           instr_i,
  input  logic [REG_WIDTH-1:0] a_i,
  input  logic [REG_WIDTH-1:0] b_i,
  input  logic                 cin_i,
  output logic [REG_WIDTH-1:0] acc_o,
  output logic                 cout_o
);

  // SUB reports a borrow in cout_o; logic ops leave cout_o low
  always_comb begin
    acc_o  = '0;
    cout_o = 1'b0;
    case (instr_i)
      4'h0: acc_o = ~a_i;
      4'h1: acc_o = a_i & b_i;
      4'h2: acc_o = a_i | b_i;
      4'h3: acc_o = a_i ^ b_i;
      4'h4: {cout_o, acc_o} = (REG_WIDTH+1)'(a_i) + (REG_WIDTH+1)'(b_i) + (REG_WIDTH+1)'(cin_i);
      4'h5: {cout_o, acc_o} = (REG_WIDTH+1)'(a_i) - (REG_WIDTH+1)'(b_i) - (REG_WIDTH+1)'(cin_i);
      4'h6: acc_o = ~(a_i & b_i);
      4'h7: acc_o = ~(a_i | b_i);
      4'h8: acc_o = ~(a_i ^ b_i);
      default: begin
        acc_o  = '0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

module alu_sched #(
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [4*NUM_REQ-1:0]         req_instr_i,
  input  logic [REG_WIDTH*NUM_REQ-1:0] req_a_i,
  input  logic [REG_WIDTH*NUM_REQ-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]           req_cin_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [REG_WIDTH-1:0]         rsp_data_o,
  output logic                         rsp_cout_o,
  output logic                         rsp_err_o,
  output logic                         busy_o,
  output logic [15:0]                  ops_done_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OPS_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [3:0]           instr_q;
  logic [REG_WIDTH-1:0] a_q, b_q;
  logic                 cin_q;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 accept;
  logic                 rsp_done;

  logic [REG_WIDTH-1:0] alu_acc;
  logic                 alu_cout;
  logic                 unsupported;

  // Rotating-priority search starting at rr_ptr and wrapping at NUM_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_found && req_valid_i[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and handshake decode; ready is forced low while reset is held
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    rsp_done    = 1'b0;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          accept                = 1'b1;
          req_ready_o[pick_idx] = reset_n;
          state_d               = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i[grant_q]) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .instr_i (instr_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .cin_i   (cin_q),
    .acc_o   (alu_acc),
    .cout_o  (alu_cout)
  );

  assign unsupported = (instr_q > 4'h8);
  assign busy_o      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_cout_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
      ops_done_o  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q  <= pick_idx;
        rr_ptr_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        instr_q  <= req_instr_i[pick_idx*4 +: 4];
        a_q      <= req_a_i[pick_idx*REG_WIDTH +: REG_WIDTH];
        b_q      <= req_b_i[pick_idx*REG_WIDTH +: REG_WIDTH];
        cin_q    <= req_cin_i[pick_idx];
      end
      // Result capture at the end of EXEC; unsupported opcodes return a zeroed error response
      if (state_q == ST_EXEC) begin
        rsp_valid_o <= NUM_REQ'(1) << grant_q;
        rsp_data_o  <= unsupported ? '0 : alu_acc;
        rsp_cout_o  <= unsupported ? 1'b0 : alu_cout;
        rsp_err_o   <= unsupported;
      end
      if (rsp_done) begin
        rsp_valid_o <= '0;
        if (ops_done_o != {OPS_W{1'b1}}) ops_done_o <= ops_done_o + OPS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: transaction-level model compared every cycle, plus directed literal checks.

module tb_alu_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_instr;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_cout;
  logic           rsp_err;
  logic           busy;
  logic [15:0]    ops_done;

  int errors = 0;
  int checks = 0;

  alu_sched #(.REG_WIDTH(W), .NUM_REQ(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_instr_i (req_instr),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cin_i   (req_cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_cout_o  (rsp_cout),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .ops_done_o  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: cycles since accept (0 idle, 1 executing, 2 responding)
  int           m_cnt, m_ptr, m_g, m_ops, w_upd, w_chk;
  logic [3:0]   m_op;
  logic [W-1:0] m_a, m_b, m_data;
  logic         m_cin, m_cout, m_err;
  logic [N-1:0] exp_ready;

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, output logic [W-1:0] r, output logic co, output logic e);
    int s;
    r = '0; co = 1'b0; e = 1'b0;
    case (op)
      4'h0: r = ~a;
      4'h1: r = a & b;
      4'h2: r = a | b;
      4'h3: r = a ^ b;
      4'h4: begin s = int'(a) + int'(b) + int'(cin); r = s[W-1:0]; co = (s >= (1 << W)); end
      4'h5: begin s = int'(a) - int'(b) - int'(cin); r = s[W-1:0]; co = (s < 0); end
      4'h6: r = ~(a & b);
      4'h7: r = ~(a | b);
      4'h8: r = ~(a ^ b);
      default: e = 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0; m_ptr = 0; m_g = 0; m_ops = 0;
      m_data = '0; m_cout = 1'b0; m_err = 1'b0;
    end else begin
      case (m_cnt)
        0: begin
          w_upd = winner(req_valid, m_ptr);
          if (w_upd >= 0) begin
            m_g   = w_upd;
            m_op  = req_instr[4*w_upd +: 4];
            m_a   = req_a[W*w_upd +: W];
            m_b   = req_b[W*w_upd +: W];
            m_cin = req_cin[w_upd];
            m_ptr = (w_upd + 1) % N;
            m_cnt = 1;
          end
        end
        1: begin
          ref_alu(m_op, m_a, m_b, m_cin, m_data, m_cout, m_err);
          m_cnt = 2;
        end
        default: begin
          if (rsp_ready[m_g]) begin
            if (m_ops < 65535) m_ops++;
            m_cnt = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    exp_ready = '0;
    if (reset_n && m_cnt == 0) begin
      w_chk = winner(req_valid, m_ptr);
      if (w_chk >= 0) exp_ready[w_chk] = 1'b1;
    end
    chk("m_req_ready", req_ready, exp_ready);
    chk("m_rsp_valid", rsp_valid, (reset_n && m_cnt == 2) ? (1 << m_g) : 0);
    chk("m_busy", busy, (reset_n && m_cnt != 0) ? 1 : 0);
    chk("m_ops_done", ops_done, m_ops);
    if (!reset_n || m_cnt == 2) begin
      chk("m_rsp_data", rsp_data, m_data);
      chk("m_rsp_cout", rsp_cout, m_cout);
      chk("m_rsp_err", rsp_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
    req_instr[4*i +: 4] = op;
    req_a[W*i +: W]     = a;
    req_b[W*i +: W]     = b;
    req_cin[i]          = cin;
    req_valid[i]        = 1'b1;
  endtask

  initial begin
    req_valid = '0; req_instr = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = '1;

    // Reset held with random inputs
    repeat (4) begin
      req_valid = N'($urandom); req_instr = (4*N)'($urandom); req_a = (W*N)'($urandom);
      req_b = (W*N)'($urandom); req_cin = N'($urandom); rsp_ready = N'($urandom);
      tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_cout", rsp_cout, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ops", ops_done, 0);
    end
    req_valid = '0; rsp_ready = '1;
    tick();
    reset_n = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 0);
    end

    // Single ADD, then ADD with carry out
    set_req(2, 4'h4, 8'h0F, 8'h01, 1'b0);
    #1 chk("add_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick();
    #1 chk("add_rsp_valid", rsp_valid, 4'b0100);
    chk("add_data", rsp_data, 8'h10);
    chk("add_cout", rsp_cout, 0);
    chk("add_err", rsp_err, 0);
    tick();
    #1 chk("add_ops", ops_done, 1);
    set_req(2, 4'h4, 8'hF0, 8'h20, 1'b0);
    #1 chk("add2_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick();
    #1 chk("add2_data", rsp_data, 8'h10);
    chk("add2_cout", rsp_cout, 1);
    tick();
    #1 chk("add2_ops", ops_done, 2);

    // Round-robin fairness from a fresh pointer
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rr_ops_cleared", ops_done, 0);
    for (int i = 0; i < N; i++) set_req(i, 4'h1, 8'hFF, 8'h3C, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", req_ready, 1 << (k % 4));
      tick();
      tick();
      #1 chk("rr_rsp_valid", rsp_valid, 1 << (k % 4));
      chk("rr_data", rsp_data, 8'h3C);
      tick();
    end
    req_valid = '0;

    // Response backpressure on requester 1 while requester 0 waits
    rsp_ready = 4'b1101;
    set_req(1, 4'h3, 8'hAA, 8'h0F, 1'b0);
    #1 chk("bp_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    set_req(0, 4'h2, 8'h12, 8'h21, 1'b0);
    #1 chk("bp_exec_ready", req_ready, 0);
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c == 5) rsp_ready = '1;
      #1 chk("bp_hold_valid", rsp_valid, 4'b0010);
      chk("bp_hold_data", rsp_data, 8'hA5);
      chk("bp_hold_ready", req_ready, 0);
      tick();
    end
    #1 chk("bp_next_grant", req_ready, 4'b0001);
    tick(); req_valid = '0;
    tick();
    #1 chk("bp_next_data", rsp_data, 8'h33);
    chk("bp_next_valid", rsp_valid, 4'b0001);
    tick();

    // Unsupported opcode
    chk("unsup_ops_before", ops_done, 8);
    set_req(3, 4'hA, 8'h55, 8'h00, 1'b0);
    #1 chk("unsup_ready", req_ready, 4'b1000);
    tick(); req_valid = '0;
    tick();
    #1 chk("unsup_err", rsp_err, 1);
    chk("unsup_data", rsp_data, 0);
    chk("unsup_cout", rsp_cout, 0);
    chk("unsup_valid", rsp_valid, 4'b1000);
    tick();
    #1 chk("unsup_ops", ops_done, 9);

    // Reset during EXEC drops the request; pointer restarts at 0
    set_req(2, 4'h4, 8'h33, 8'h44, 1'b1);
    #1 chk("mid_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1 reset_n = 1'b0;
    #1 chk("mid_busy", busy, 0);
    chk("mid_valid", rsp_valid, 0);
    chk("mid_ops", ops_done, 0);
    set_req(1, 4'h2, 8'h0F, 8'hF0, 1'b0);
    set_req(3, 4'h1, 8'hF0, 8'h3C, 1'b0);
    #1 chk("mid_rst_ready", req_ready, 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1 chk("mid_first_grant", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    #1 chk("mid_rsp_valid", rsp_valid, 4'b0010);
    chk("mid_rsp_data", rsp_data, 8'hFF);
    tick();
    #1 chk("mid_second_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (4) tick();
    #1 chk("end_ops", ops_done, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares a single `alu` instance (combinational variant, `USE_PIPELINED_ALU=0`) between `NUM_REQ` requesters. It sits between the issue logic of several execution clients and the ALU. Each requester hands over one operation with a valid/ready handshake. The scheduler registers the operands, executes the operation on the shared ALU, and returns the registered result to the granted requester through a valid/ready response channel.

## Interface
Parameters:
- `REG_WIDTH`, 8, operand/result width passed to the internal `alu`.
- `NUM_REQ`, 4, number of requesters; legal range 2..8.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  per-requester operation valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_instr_i`  in  4*NUM_REQ  opcode of requester i at bits [4i+3:4i].
- `req_a_i`  in  REG_WIDTH*NUM_REQ  operand A of requester i, packed the same way.
- `req_b_i`  in  REG_WIDTH*NUM_REQ  operand B of requester i.
- `req_cin_i`  in  NUM_REQ  carry-in of requester i.
- `rsp_valid_o`  out  NUM_REQ  one-hot response valid, addressed to the owning requester.
- `rsp_ready_i`  in  NUM_REQ  per-requester response accept.
- `rsp_data_o`  out  REG_WIDTH  shared result bus.
- `rsp_cout_o`  out  1  carry-out of the result.
- `rsp_err_o`  out  1  the operation carried an unsupported opcode.
- `busy_o`  out  1  the FSM is not in IDLE.
- `ops_done_o`  out  16  count of completed responses, saturating.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - If any `req_valid_i` is set, select the first set index searching upward from `rr_ptr` and wrapping at `NUM_REQ`.
  - Assert that requester's `req_ready_o` bit combinationally in the same cycle.
  - On the clock edge, latch opcode, A, B, cin and the grant index, then go to EXEC.
  - If no `req_valid_i` is set, stay in IDLE with `req_ready_o` = 0.
- **rr_ptr update:** on each accept, `rr_ptr` = grant + 1 mod `NUM_REQ`. Its reset value is 0.
- **EXEC:**
  - The ALU is driven only from the latched registers.
  - At the end of the cycle, register `acc_o` into the data register and `cout_o` into the carry register, then go to RESP.
  - Opcodes 0x0–0x8 (NOT, AND, OR, XOR, ADD, SUB, NAND, NOR, XNOR) are supported.
  - Opcodes 0x9–0xF (shift/rotate and undefined) are unsupported. For these, register err = 1, data = 0 and cout = 0 instead of the ALU outputs.
- **RESP:**
  - `rsp_valid_o` = one-hot(grant).
  - `rsp_data_o`, `rsp_cout_o` and `rsp_err_o` are held stable.
  - When `rsp_ready_i[grant]` is 1: increment `ops_done_o` (saturating at 0xFFFF), clear `rsp_valid_o` and go to IDLE.
  - `rsp_ready_i` bits of other requesters are ignored.
- `req_ready_o` is 0 in EXEC and RESP. New requests wait.
- **Requester rules:**
  - A requester must hold valid and payload stable until it is accepted.
  - Payload changes while not granted are legal and simply sampled at grant.
- **Simultaneous events:**
  - Several valids in the same cycle: only the rotating-priority winner is accepted.
  - A requester whose response is pending may present a new request. It is considered only on the next IDLE cycle.
- **Reset:**
  - Asynchronous `reset_n` low forces the state, `rr_ptr`, all registers and all outputs to 0 immediately.
  - Any in-flight operation is dropped without a response.
  - Reset values of all outputs are 0: `req_ready_o`, `rsp_valid_o`, `rsp_data_o`, `rsp_cout_o`, `rsp_err_o`, `busy_o`, `ops_done_o`.

## Timing
- Accept at cycle T (IDLE, `req_valid_i` & `req_ready_o` both set).
- EXEC at T+1.
- `rsp_valid_o` is first high at T+2; latency is 2 cycles from accept to response.
- If `rsp_ready_i` is high at T+2, the FSM is in IDLE at T+3 and can accept the next request at T+3.
- Maximum throughput is one operation per 3 cycles.
- Response backpressure of N cycles stretches RESP by N cycles. No request is accepted during that time.
- `busy_o` is high in EXEC and RESP. It is combinational from the state register and glitch-free.
- The ALU path is entirely register-to-register (latched operands to result register). There is no combinational path from `req_*` to `rsp_*`.
- `req_ready_o` depends combinationally on `req_valid_i`, the state and `rr_ptr`.

## Test plan
- **Reset:** hold `reset_n` = 0 with random inputs → every output is 0. Release, drive all valid = 0 for 5 cycles → `busy_o` = 0 and `req_ready_o` = 0 throughout.
- **Single ADD:** requester 2, instr 0x4, A = 0x0F, B = 0x01, cin = 0, `rsp_ready_i` = all ones. Expected:
  - `req_ready_o` = 0100 at T.
  - `rsp_valid_o` = 0100 at T+2 with `rsp_data_o` = 0x10, cout = 0, err = 0.
  - `ops_done_o` = 1 at T+3.
  - Repeat with A = 0xF0, B = 0x20 → data 0x10, cout = 1.
- **Round-robin fairness:** all four requesters continuously valid with AND, A = 0xFF, B = 0x3C, `rsp_ready_i` = 1111. Expected:
  - Grants in order 0, 1, 2, 3, 0, 1 at cycles T, T+3, T+6, …
  - Each response has data 0x3C.
- **Backpressure:** requester 1 issues XOR 0xAA^0x0F with `rsp_ready_i[1]` = 0 for 5 cycles while requester 0 is valid. Expected:
  - `rsp_valid_o` = 0010 and data 0xA5 are stable for 6 cycles.
  - `req_ready_o` = 0 during that time.
  - Requester 0 is accepted on the first IDLE cycle after the response handshake.
- **Unsupported opcode:** requester 3 issues instr 0xA, A = 0x55 → response has err = 1, data = 0x00, cout = 0. `ops_done_o` increments.
- **Reset mid-operation:** assert `reset_n` = 0 during EXEC of a requester-2 request. Expected:
  - All outputs 0 immediately; no response is ever produced for that request.
  - After release with requesters 1 and 3 valid, requester 1 is granted first (`rr_ptr` = 0).
